ffstdp_rmw_sequencer: RTL and testbench

//  Training-phase read-modify-write sequencer for the synaptic weight SRAM (dual-port: 1R + 1W).
//  On a training time-reference event it walks every (pre, post) synapse in row-major order.
//  Per synapse it reads the weight, feeds the spike counts to the FF-STDP update unit, and writes the unit's result back.

---
 rtl/ffstdp_rmw_sequencer_if.sv | 52 +++++
 rtl/ffstdp_rmw_sequencer.sv | 148 ++++++++++++++
 tb/tb_ffstdp_rmw_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ffstdp_rmw_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : ffstdp_rmw_sequencer_if
//  Purpose  : Bundles the control, count-regfile, update-unit and SRAM signals
//             of the FF-STDP read-modify-write sequencer.
//  Modports : master - the sequencer itself
//             slave  - the surrounding environment (regfiles, SRAM, update unit)
//  Revision : 1.0  initial release
// ============================================================================
interface ffstdp_rmw_sequencer_if #(
   parameter int PRE_ADDR_W     = 8,
   parameter int POST_ADDR_W    = 7,
   parameter int PRE_CNT_WIDTH  = 8,
   parameter int POST_CNT_WIDTH = 7,
   parameter int WEIGHT_WIDTH   = 8
);
   // control
   logic                              START;
   logic                              IS_TRAIN;
   logic                              HOLD;
   logic                              BUSY;
   logic                              DONE;
   // spike-count register files
   logic [PRE_ADDR_W-1:0]             PRE_CNT_RADDR;
   logic [PRE_CNT_WIDTH-1:0]          PRE_CNT_RDATA;
   logic [POST_ADDR_W-1:0]            POST_CNT_RADDR;
   logic [POST_CNT_WIDTH-1:0]         POST_CNT_RDATA;
   // FF-STDP update unit
   logic [PRE_CNT_WIDTH-1:0]          UPD_PRE_CNT;
   logic [POST_CNT_WIDTH-1:0]         UPD_POST_CNT;
   logic                              UPD_TREF_EVENT;
   logic signed [WEIGHT_WIDTH-1:0]    UPD_WSYN_NEW;
   // weight SRAM (1R + 1W)
   logic                              SRAM_RE;
   logic [PRE_ADDR_W+POST_ADDR_W-1:0] SRAM_RADDR;
   logic                              SRAM_WE;
   logic [PRE_ADDR_W+POST_ADDR_W-1:0] SRAM_WADDR;
   logic signed [WEIGHT_WIDTH-1:0]    SRAM_WDATA;

   modport master (
      input  START, IS_TRAIN, HOLD, PRE_CNT_RDATA, POST_CNT_RDATA, UPD_WSYN_NEW,
      output BUSY, DONE, PRE_CNT_RADDR, POST_CNT_RADDR, UPD_PRE_CNT, UPD_POST_CNT,
             UPD_TREF_EVENT, SRAM_RE, SRAM_RADDR, SRAM_WE, SRAM_WADDR, SRAM_WDATA
   );

   modport slave (
      output START, IS_TRAIN, HOLD, PRE_CNT_RDATA, POST_CNT_RDATA, UPD_WSYN_NEW,
      input  BUSY, DONE, PRE_CNT_RADDR, POST_CNT_RADDR, UPD_PRE_CNT, UPD_POST_CNT,
             UPD_TREF_EVENT, SRAM_RE, SRAM_RADDR, SRAM_WE, SRAM_WADDR, SRAM_WDATA
   );
endinterface
`default_nettype wire

// File: rtl/ffstdp_rmw_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ffstdp_rmw_sequencer
//  Purpose  : Training-phase read-modify-write sequencer for the synaptic
//             weight SRAM. On a training time-reference event it walks every
//             (pre, post) synapse row-major, reads the weight, presents the
//             spike counts to the FF-STDP update unit and writes the updated
//             weight back two cycles after the read.
//  Ports    : CLK  - clock, rising edge
//             RST  - synchronous active-high reset (aborts a running sequence)
//             bus  - ffstdp_rmw_sequencer_if.master:
//                    START/IS_TRAIN/HOLD in, BUSY/DONE out,
//                    count-regfile indices out / data in,
//                    update-unit counts + TREF out / new weight in,
//                    SRAM read and write ports out
//  Revision : 1.0  initial release
// ============================================================================
module ffstdp_rmw_sequencer #(
   parameter int N_PRE          = 256,
   parameter int N_POST         = 128,
   parameter int PRE_ADDR_W     = $clog2(N_PRE),
   parameter int POST_ADDR_W    = $clog2(N_POST),
   parameter int PRE_CNT_WIDTH  = 8,
   parameter int POST_CNT_WIDTH = 7,
   parameter int WEIGHT_WIDTH   = 8,
   parameter bit SKIP_ZERO_PRE  = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RST,
   ffstdp_rmw_sequencer_if.master bus
);

   localparam int                     c_ADDR_W    = PRE_ADDR_W + POST_ADDR_W;
   localparam logic [PRE_ADDR_W-1:0]  c_PRE_LAST  = PRE_ADDR_W'(N_PRE - 1);
   localparam logic [POST_ADDR_W-1:0] c_POST_LAST = POST_ADDR_W'(N_POST - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                 r_state;
   logic [PRE_ADDR_W-1:0]  r_pre_idx;
   logic [POST_ADDR_W-1:0] r_post_idx;
   // write pipeline: stage 1 = SRAM data cycle, stage 2 = write-back cycle
   logic                   r_s1_vld;
   logic [c_ADDR_W-1:0]    r_s1_addr;
   logic                   r_s2_vld;
   logic [c_ADDR_W-1:0]    r_s2_addr;
   logic                   r_done;

   logic                   w_run_act;
   logic                   w_skip;
   logic                   w_issue;
   logic                   w_row_end;
   logic                   w_last;
   logic [c_ADDR_W-1:0]    w_raddr;

   // The skip decision needs the pre count of the current row, which the
   // regfile returns combinationally, so read issue is decided in-cycle.
   assign w_run_act = (r_state == S_RUN) && !bus.HOLD;
   assign w_skip    = SKIP_ZERO_PRE && w_run_act && (r_post_idx == '0)
                      && (bus.PRE_CNT_RDATA == '0);
   assign w_issue   = w_run_act && !w_skip;
   assign w_row_end = w_skip || (w_issue && (r_post_idx == c_POST_LAST));
   assign w_last    = w_row_end && (r_pre_idx == c_PRE_LAST);
   assign w_raddr   = {r_pre_idx, r_post_idx};

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_pre_idx  <= '0;
         r_post_idx <= '0;
         r_s1_vld   <= 1'b0;
         r_s1_addr  <= '0;
         r_s2_vld   <= 1'b0;
         r_s2_addr  <= '0;
         r_done     <= 1'b0;
      end else begin
         // The pipe shifts every cycle; HOLD only blocks new reads.
         r_s1_vld  <= w_issue;
         r_s1_addr <= w_raddr;
         r_s2_vld  <= r_s1_vld;
         r_s2_addr <= r_s1_addr;
         r_done    <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (bus.START && bus.IS_TRAIN) begin
                  r_state    <= S_RUN;
                  r_pre_idx  <= '0;
                  r_post_idx <= '0;
               end
            end

            S_RUN: begin
               if (w_row_end) begin
                  r_post_idx <= '0;
                  r_pre_idx  <= r_pre_idx + 1'b1;
               end else if (w_issue) begin
                  r_post_idx <= r_post_idx + 1'b1;
               end

               if (w_last) begin
                  r_pre_idx <= '0;
                  // A skipped last row with nothing left in stage 1 means the
                  // pipe is empty next cycle: finish without a drain cycle.
                  if (w_skip && !r_s1_vld) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_DRAIN;
                  end
               end
            end

            S_DRAIN: begin
               // Stage 1 empty now means the final write is in stage 2 this
               // cycle, so DONE lands the cycle after the last write.
               if (!r_s1_vld) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.BUSY           = (r_state != S_IDLE);
   assign bus.DONE           = r_done;
   assign bus.PRE_CNT_RADDR  = r_pre_idx;
   assign bus.POST_CNT_RADDR = r_post_idx;
   assign bus.UPD_PRE_CNT    = bus.PRE_CNT_RDATA;
   assign bus.UPD_POST_CNT   = bus.POST_CNT_RDATA;
   assign bus.UPD_TREF_EVENT = r_s1_vld | r_s2_vld;
   assign bus.SRAM_RE        = w_issue;
   assign bus.SRAM_RADDR     = w_raddr;
   assign bus.SRAM_WE        = r_s2_vld;
   assign bus.SRAM_WADDR     = r_s2_addr;
   assign bus.SRAM_WDATA     = bus.UPD_WSYN_NEW;

endmodule
`default_nettype wire

// File: tb/tb_ffstdp_rmw_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ffstdp_rmw_sequencer
//  Purpose  : Self-checking bench for ffstdp_rmw_sequencer (2 x 3 synapses).
//             Models the weight SRAM, the count regfiles and an update unit
//             returning WSYN_CURR+1 with two-cycle latency; expected reads and
//             writes are queued when stimulus is driven and popped on output.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ffstdp_rmw_sequencer;

   localparam int N_PRE  = 2;
   localparam int N_POST = 3;
   localparam int PRE_W  = 1;
   localparam int POST_W = 2;

   typedef struct {
      int addr;
      int data;
      int cyc;
   } exp_t;

   logic CLK = 1'b0;
   logic RST;

   ffstdp_rmw_sequencer_if #(
      .PRE_ADDR_W(PRE_W), .POST_ADDR_W(POST_W),
      .PRE_CNT_WIDTH(8), .POST_CNT_WIDTH(7), .WEIGHT_WIDTH(8)
   ) bus_if ();

   ffstdp_rmw_sequencer #(
      .N_PRE(N_PRE), .N_POST(N_POST), .PRE_ADDR_W(PRE_W), .POST_ADDR_W(POST_W),
      .PRE_CNT_WIDTH(8), .POST_CNT_WIDTH(7), .WEIGHT_WIDTH(8), .SKIP_ZERO_PRE(1'b1)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus_if)
   );

   always #5 CLK = ~CLK;

   // environment models
   logic [7:0] mem [0:7];
   logic [7:0] pre_cnt [0:1];
   logic [6:0] post_cnt [0:3];
   logic [7:0] rd_data = 8'd0;
   logic [7:0] upd_q   = 8'd0;
   int         cyc     = 0;
   int         c0      = 0;

   assign bus_if.PRE_CNT_RDATA  = pre_cnt[bus_if.PRE_CNT_RADDR];
   assign bus_if.POST_CNT_RDATA = post_cnt[bus_if.POST_CNT_RADDR];
   assign bus_if.UPD_WSYN_NEW   = upd_q;

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (bus_if.SRAM_RE) rd_data <= mem[bus_if.SRAM_RADDR];
      upd_q <= rd_data + 8'd1;
      if (bus_if.SRAM_WE) mem[bus_if.SRAM_WADDR] <= bus_if.SRAM_WDATA;
   end

   // scoreboard state
   exp_t wq[$];
   exp_t rq[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
   int   done_rel = -1, busy_rise = -1, busy_last = -1;
   logic busy_prev = 1'b0;
   logic rd_chk_en = 1'b1;

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   // output monitor, sampled mid-cycle
   always @(negedge CLK) begin
      int   rel;
      exp_t e;
      rel = cyc - c0;
      if (bus_if.SRAM_WE) begin
         wr_cnt++;
         chk("write_expected", int'(wq.size() != 0), 1);
         if (wq.size() != 0) begin
            e = wq.pop_front();
            chk("wr_addr", int'(bus_if.SRAM_WADDR), e.addr);
            chk("wr_data", int'(bus_if.SRAM_WDATA), e.data);
            chk("wr_cycle", rel, e.cyc);
         end
      end
      if (bus_if.SRAM_RE) begin
         rd_cnt++;
         if (rd_chk_en) begin
            chk("read_expected", int'(rq.size() != 0), 1);
            if (rq.size() != 0) begin
               e = rq.pop_front();
               chk("rd_addr", int'(bus_if.SRAM_RADDR), e.addr);
               chk("rd_cycle", rel, e.cyc);
            end
         end
      end
      if (bus_if.DONE) begin
         done_cnt++;
         done_rel = rel;
      end
      if (bus_if.BUSY && !busy_prev) busy_rise = rel;
      if (bus_if.BUSY) busy_last = rel;
      busy_prev = bus_if.BUSY;
   end

   task automatic push_wr(input int a, input int d, input int c);
      exp_t e;
      e.addr = a; e.data = d; e.cyc = c;
      wq.push_back(e);
   endtask

   task automatic push_rd(input int a, input int c);
      exp_t e;
      e.addr = a; e.data = 0; e.cyc = c;
      rq.push_back(e);
   endtask

   task automatic init_mem();
      for (int i = 0; i < 8; i++) mem[i] = 8'(i);
   endtask

   // pulses START for one cycle; that cycle becomes relative cycle 0
   task automatic start_seq();
      @(posedge CLK); #1;
      bus_if.START = 1'b1;
      c0 = cyc;
      @(posedge CLK); #1;
      bus_if.START = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      int d0;
      n  = 0;
      d0 = done_cnt;
      while (done_cnt == d0 && n < budget) begin
         @(posedge CLK);
         n++;
      end
      chk("done_within_budget", int'(done_cnt != d0), 1);
      repeat (4) @(posedge CLK);
      #1;
   endtask

   // full 2x3 walk, all counts non-zero, no HOLD
   task automatic push_full(input int rd_c0, input int wr_c0);
      int a_tab [6];
      a_tab = '{0, 1, 2, 4, 5, 6};
      for (int i = 0; i < 6; i++) begin
         push_rd(a_tab[i], rd_c0 + i);
         push_wr(a_tab[i], a_tab[i] + 1, wr_c0 + i);
      end
   endtask

   initial begin
      int w0, r0, d0;
      int a_tab [6];
      int rc_tab [6];
      int wc_tab [6];

      RST = 1'b1;
      bus_if.START    = 1'b0;
      bus_if.IS_TRAIN = 1'b1;
      bus_if.HOLD     = 1'b0;
      for (int i = 0; i < 2; i++) pre_cnt[i] = 8'd3;
      for (int i = 0; i < 4; i++) post_cnt[i] = 7'd3;
      init_mem();

      // reset state
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_busy", int'(bus_if.BUSY), 0);
      chk("rst_done", int'(bus_if.DONE), 0);
      chk("rst_re",   int'(bus_if.SRAM_RE), 0);
      chk("rst_we",   int'(bus_if.SRAM_WE), 0);
      chk("rst_tref", int'(bus_if.UPD_TREF_EVENT), 0);
      RST = 1'b0;

      // 1: plain walk
      init_mem();
      push_full(1, 3);
      w0 = wr_cnt;
      start_seq();
      #1;
      chk("t1_tref_idle_c1", int'(bus_if.UPD_TREF_EVENT), 0);
      wait_done(40);
      chk("t1_done_cyc",  done_rel, 9);
      chk("t1_busy_rise", busy_rise, 1);
      chk("t1_busy_last", busy_last, 8);
      chk("t1_wr_cnt",    wr_cnt - w0, 6);
      chk("t1_wq_left",   wq.size(), 0);
      chk("t1_rq_left",   rq.size(), 0);
      chk("t1_mem5",      int'(mem[5]), 6);

      // 2: HOLD in cycles 2-3
      init_mem();
      a_tab  = '{0, 1, 2, 4, 5, 6};
      rc_tab = '{1, 4, 5, 6, 7, 8};
      wc_tab = '{3, 6, 7, 8, 9, 10};
      for (int i = 0; i < 6; i++) begin
         push_rd(a_tab[i], rc_tab[i]);
         push_wr(a_tab[i], a_tab[i] + 1, wc_tab[i]);
      end
      w0 = wr_cnt;
      start_seq();
      @(posedge CLK); #1;
      bus_if.HOLD = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      bus_if.HOLD = 1'b0;
      wait_done(40);
      chk("t2_done_cyc", done_rel, 11);
      chk("t2_wr_cnt",   wr_cnt - w0, 6);
      chk("t2_wq_left",  wq.size(), 0);
      chk("t2_rq_left",  rq.size(), 0);

      // 3: row 0 skipped
      init_mem();
      pre_cnt[0] = 8'd0;
      for (int i = 0; i < 3; i++) begin
         push_rd(4 + i, 2 + i);
         push_wr(4 + i, 5 + i, 4 + i);
      end
      w0 = wr_cnt;
      start_seq();
      wait_done(40);
      chk("t3_done_cyc",  done_rel, 7);
      chk("t3_busy_last", busy_last, 6);
      chk("t3_wr_cnt",    wr_cnt - w0, 3);
      chk("t3_mem1_kept", int'(mem[1]), 1);
      chk("t3_wq_left",   wq.size(), 0);
      pre_cnt[0] = 8'd3;

      // 4: reset in cycle 4 aborts; then a fresh full run
      init_mem();
      rd_chk_en = 1'b0;
      push_wr(0, 1, 3);
      push_wr(1, 2, 4);
      w0 = wr_cnt;
      d0 = done_cnt;
      start_seq();
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      chk("t4_busy_c5", int'(bus_if.BUSY), 0);
      chk("t4_we_c5",   int'(bus_if.SRAM_WE), 0);
      chk("t4_tref_c5", int'(bus_if.UPD_TREF_EVENT), 0);
      repeat (5) @(posedge CLK);
      #1;
      chk("t4_abort_wr_cnt", wr_cnt - w0, 2);
      chk("t4_abort_done",   done_cnt - d0, 0);
      chk("t4_wq_left",      wq.size(), 0);
      rd_chk_en = 1'b1;
      init_mem();
      push_full(1, 3);
      w0 = wr_cnt;
      start_seq();
      wait_done(40);
      chk("t4_rerun_done_cyc", done_rel, 9);
      chk("t4_rerun_wr_cnt",   wr_cnt - w0, 6);

      // 5: START ignored when not training or already busy
      w0 = wr_cnt;
      r0 = rd_cnt;
      d0 = done_cnt;
      @(posedge CLK); #1;
      bus_if.IS_TRAIN = 1'b0;
      bus_if.START    = 1'b1;
      @(posedge CLK); #1;
      bus_if.START    = 1'b0;
      bus_if.IS_TRAIN = 1'b1;
      repeat (6) @(posedge CLK);
      #1;
      chk("t5_notrain_busy", int'(bus_if.BUSY), 0);
      chk("t5_notrain_rd",   rd_cnt - r0, 0);
      chk("t5_notrain_wr",   wr_cnt - w0, 0);
      chk("t5_notrain_done", done_cnt - d0, 0);
      init_mem();
      push_full(1, 3);
      w0 = wr_cnt;
      d0 = done_cnt;
      start_seq();
      @(posedge CLK);
      @(posedge CLK); #1;
      bus_if.START = 1'b1;
      @(posedge CLK); #1;
      bus_if.START = 1'b0;
      wait_done(40);
      repeat (6) @(posedge CLK);
      #1;
      chk("t5_done_cyc",  done_rel, 9);
      chk("t5_done_cnt",  done_cnt - d0, 1);
      chk("t5_wr_cnt",    wr_cnt - w0, 6);
      chk("t5_busy_idle", int'(bus_if.BUSY), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
